// File: rtl/bcd_timer_pkg.sv
// Shared types, BCD constants and nibble helpers for the cascaded BCD timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_NINE = 4'd9;

  function automatic logic [3:0] bcd_sat(input logic [3:0] nibble);
    return (nibble > BCD_NINE) ? BCD_NINE : nibble;
  endfunction

  function automatic logic [3:0] bcd_step(input logic [3:0] nibble, input logic up);
    if (up)
      return (nibble >= BCD_NINE) ? BCD_ZERO : nibble + 4'd1;
    else
      return (nibble == BCD_ZERO) ? BCD_NINE : nibble - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_timer_digit.sv
// One BCD digit of the cascade: load has priority over step, wraps 9<->0.
module bcd_timer_digit
  import bcd_timer_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic       step,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dir,
  output logic [3:0] value,
  output logic       at_wrap
);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)
      value <= BCD_ZERO;
    else if (load)
      value <= load_val;
    else if (step)
      value <= bcd_step(value, dir);
  end

  assign at_wrap = dir ? (value == BCD_NINE) : (value == BCD_ZERO);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Sequencing controller for a cascaded BCD up/down timer with prescaler.
// Optional macro BCD_TIMER_AUTO_RELOAD_EN: terminal count reloads instead of stopping.
//
// state    | meaning
// ST_IDLE  | stopped, Q holds, LOAD accepted
// ST_RUN   | prescaler running, digits step on each tick
// ST_PAUSE | stopped mid-count, prescaler phase held
// ST_DONE  | terminal count reached, Q holds, LOAD accepted
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  LOAD,
  input  logic                  UP,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  RUNNING,
  output logic                  PAUSED,
  output logic                  DONE,
  output logic                  CO
);

  localparam int QW    = 4 * DIGITS;
  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);

  state_t            state;
  logic [QW-1:0]     limit;
  logic              dir;
  logic [PSC_W-1:0]  psc;
  logic              co_q;

  logic [DIGITS-1:0] at_wrap;
  logic [DIGITS-1:0] step_en;
  logic [QW-1:0]     limit_sat;
  logic [QW-1:0]     q_stepped;
  logic [QW-1:0]     load_val;
  logic              load_ok;
  logic              tick;
  logic              q_term;
  logic              step_term;
  logic              reload;
  logic              dig_load;

  assign load_ok = LOAD && ((state == ST_IDLE) || (state == ST_DONE));
  assign tick    = (state == ST_RUN) && !STOP && (psc == PSC_LAST);
  assign q_term  = dir ? (Q == limit) : (Q == '0);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  // Terminal value has been displayed for a full period; this tick restarts the count.
  assign reload = tick && q_term;
`else
  assign reload = 1'b0;
`endif

  always_comb begin
    limit_sat = '0;
    for (int i = 0; i < DIGITS; i++)
      limit_sat[4*i +: 4] = bcd_sat(D[4*i +: 4]);
  end

  always_comb begin
    step_en    = '0;
    step_en[0] = tick && !reload;
    for (int i = 1; i < DIGITS; i++)
      step_en[i] = step_en[i-1] && at_wrap[i-1];
  end

  // Look-ahead of the post-step count so CO lands on the same edge as the terminal value.
  always_comb begin
    q_stepped = Q;
    for (int i = 0; i < DIGITS; i++)
      if (step_en[i])
        q_stepped[4*i +: 4] = bcd_step(Q[4*i +: 4], dir);
  end

  assign step_term = dir ? (q_stepped == limit) : (q_stepped == '0);
  assign dig_load  = load_ok || reload;
  assign load_val  = load_ok ? (UP ? '0 : limit_sat) : (dir ? '0 : limit);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_timer_digit u_digit (
      .CLK      (CLK),
      .CLR      (CLR),
      .step     (step_en[g]),
      .load     (dig_load),
      .load_val (load_val[4*g +: 4]),
      .dir      (dir),
      .value    (Q[4*g +: 4]),
      .at_wrap  (at_wrap[g])
    );
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= ST_IDLE;
      limit <= '0;
      dir   <= 1'b0;
      psc   <= '0;
      co_q  <= 1'b0;
    end else begin
      co_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_ok) begin
            limit <= limit_sat;
            dir   <= UP;
          end else if (START && !STOP) begin
            if (q_term) begin
              state <= ST_DONE;
              co_q  <= 1'b1;
            end else begin
              state <= ST_RUN;
              psc   <= '0;
            end
          end
        end
        ST_RUN: begin
          if (STOP) begin
            state <= ST_PAUSE;
          end else begin
            psc <= tick ? '0 : psc + PSC_ONE;
            if (tick && !reload && step_term) begin
              co_q <= 1'b1;
`ifndef BCD_TIMER_AUTO_RELOAD_EN
              state <= ST_DONE;
`endif
            end
          end
        end
        ST_PAUSE: begin
          if (STOP) begin
            state <= ST_IDLE;
            psc   <= '0;
          end else if (START) begin
            state <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (load_ok) begin
            limit <= limit_sat;
            dir   <= UP;
            state <= ST_IDLE;
          end else if (STOP) begin
            state <= ST_IDLE;
            psc   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign RUNNING = (state == ST_RUN);
  assign PAUSED  = (state == ST_PAUSE);
  assign DONE    = (state == ST_DONE);
  assign CO      = co_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Scoreboard bench for bcd_timer_ctrl: integer-count reference model feeds an expectation queue.
module tb_bcd_timer_ctrl;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;
  localparam int QW       = 4 * DIGITS;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          CLR = 1'b1;
  logic          START = 1'b0;
  logic          STOP = 1'b0;
  logic          LOAD = 1'b0;
  logic          UP = 1'b0;
  logic [QW-1:0] D = '0;
  logic [QW-1:0] Q;
  logic          RUNNING, PAUSED, DONE, CO;

  always #5 CLK = ~CLK;

  bcd_timer_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .CLK(CLK), .CLR(CLR), .START(START), .STOP(STOP), .LOAD(LOAD), .UP(UP),
    .D(D), .Q(Q), .RUNNING(RUNNING), .PAUSED(PAUSED), .DONE(DONE), .CO(CO)
  );

  typedef struct {
    logic [QW-1:0] q;
    logic running, paused, done, co;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t m_st  = M_IDLE;
  int      m_cnt = 0;
  int      m_lim = 0;
  int      m_psc = 0;
  bit      m_up  = 1'b0;
  bit      m_co  = 1'b0;

  function automatic logic [QW-1:0] to_bcd(input int v);
    logic [QW-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int preset_of(input logic [QW-1:0] d);
    int r = 0;
    int w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      logic [3:0] nib;
      nib = d[4*i +: 4];
      r += ((nib > 4'd9) ? 9 : int'(nib)) * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic bit m_term();
    return m_up ? (m_cnt == m_lim) : (m_cnt == 0);
  endfunction

  task automatic m_load(input bit up, input logic [QW-1:0] d);
    m_lim = preset_of(d);
    m_up  = up;
    m_cnt = up ? 0 : m_lim;
  endtask

  // One rising edge of the reference model.
  task automatic model_edge(input bit clr, input bit start, input bit stop,
                            input bit load, input bit up, input logic [QW-1:0] d);
    m_co = 1'b0;
    if (clr) begin
      m_st = M_IDLE; m_cnt = 0; m_lim = 0; m_up = 1'b0; m_psc = 0;
      return;
    end
    case (m_st)
      M_IDLE: begin
        if (load) m_load(up, d);
        else if (stop) begin end
        else if (start) begin
          if (m_term()) begin m_st = M_DONE; m_co = 1'b1; end
          else begin m_st = M_RUN; m_psc = 0; end
        end
      end
      M_RUN: begin
        if (stop) m_st = M_PAUSE;
        else if (m_psc == PRESCALE - 1) begin
          m_psc = 0;
          if (AR && m_term()) m_cnt = m_up ? 0 : m_lim;
          else begin
            m_cnt = m_up ? m_cnt + 1 : m_cnt - 1;
            if (m_term()) begin
              m_co = 1'b1;
              if (!AR) m_st = M_DONE;
            end
          end
        end else m_psc++;
      end
      M_PAUSE: begin
        if (stop) begin m_st = M_IDLE; m_psc = 0; end
        else if (start) m_st = M_RUN;
      end
      M_DONE: begin
        if (load) begin m_load(up, d); m_st = M_IDLE; end
        else if (stop) begin m_st = M_IDLE; m_psc = 0; end
      end
      default: m_st = M_IDLE;
    endcase
  endtask

  task automatic drive(input bit clr, input bit start, input bit stop,
                       input bit load, input bit up, input logic [QW-1:0] d);
    exp_t e;
    @(negedge CLK);
    CLR = clr; START = start; STOP = stop; LOAD = load; UP = up; D = d;
    model_edge(clr, start, stop, load, up, d);
    e.q = to_bcd(m_cnt);
    e.running = (m_st == M_RUN);
    e.paused  = (m_st == M_PAUSE);
    e.done    = (m_st == M_DONE);
    e.co      = m_co;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_load(input bit up, input logic [QW-1:0] d);
    drive(1'b0, 1'b0, 1'b0, 1'b1, up, d);
  endtask

  task automatic do_start();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_stop();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  // CLR raised between edges must clear outputs without waiting for a clock.
  task automatic async_clr_check();
    @(posedge CLK);
    #3;
    CLR = 1'b1;
    #1;
    vectors++;
    if (Q !== '0 || RUNNING !== 1'b0 || PAUSED !== 1'b0 || DONE !== 1'b0 || CO !== 1'b0) begin
      miscompares++;
      $display("FAIL async_clr: got Q=%h RUNNING=%b PAUSED=%b DONE=%b CO=%b, want Q=00 and all flags 0",
               Q, RUNNING, PAUSED, DONE, CO);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  always @(posedge CLK) cyc++;

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (Q !== e.q || RUNNING !== e.running || PAUSED !== e.paused ||
            DONE !== e.done || CO !== e.co) begin
          miscompares++;
          $display("FAIL cycle_%0d: got Q=%h R=%b P=%b D=%b CO=%b, want Q=%h R=%b P=%b D=%b CO=%b",
                   cyc, Q, RUNNING, PAUSED, DONE, CO, e.q, e.running, e.paused, e.done, e.co);
        end
      end
    end
  end

  initial begin : stimulus
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Down count 03 -> 00, then hold in DONE.
    do_load(1'b0, 8'h03);
    do_start();
    idle(4 * 3 + 20);

    // Up count to 12 through the 09 -> 10 ripple.
    do_load(1'b1, 8'h12);
    do_start();
    idle(4 * 12 + 6);

    // Pause/resume keeps prescaler phase; double STOP aborts.
    do_load(1'b0, 8'h20);
    do_start();
    idle(8);
    idle(2);
    do_stop();
    idle(10);
    do_start();
    idle(3);
    do_stop();
    do_stop();
    idle(3);

    // Saturating load, LOAD ignored while running, START+STOP resolves to STOP.
    do_load(1'b0, 8'h3C);
    do_start();
    idle(5);
    do_load(1'b1, 8'h55);
    idle(3);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    do_stop();

    // Already terminal on START, then asynchronous clear mid-run.
    do_load(1'b0, 8'h00);
    do_start();
    idle(2);
    do_stop();
    do_load(1'b0, 8'h05);
    do_start();
    idle(5);
    async_clr_check();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Short down count; auto-reload builds cycle 02,01,00 repeatedly.
    do_load(1'b0, 8'h02);
    do_start();
    idle(4 * 6 + 2);
    do_stop();
    do_stop();

    // Up count with limit 00 goes straight to DONE.
    do_load(1'b1, 8'h00);
    do_start();
    do_stop();

    for (int k = 0; k < 800; k++) begin
      bit clr, start, stop, load, up;
      logic [QW-1:0] d;
      clr   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      load  = ($urandom_range(0, 9) == 0);
      up    = $urandom_range(0, 1);
      d     = ($urandom_range(0, 1) == 0) ? QW'($urandom_range(0, 255)) : QW'($urandom_range(0, 5));
      drive(clr, start, stop, load, up, d);
    end

    repeat (3) @(posedge CLK);
    #4;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
